// File: rtl/cpps_color_emulator.sv
// Colour-sensor stand-in: NCO square-wave generator whose frequency tracks the RGB channel chosen
// by the sensor's S3/S2 select, with staged colour updates and an outSQ rising-edge counter.
module cpps_color_emulator #(
   parameter int ACC_W    = 32,
   parameter int STEP_RST = 24570,
   parameter int EDGE_W   = 16
) (
   input  logic        csi_CLK,
   input  logic        csi_reset,
   input  logic        avs_chipselect,
   input  logic [4:0]  avs_address,
   input  logic        avs_read,
   output logic [31:0] avs_readdata,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic [1:0]  coe_Sctrl,
   output logic        coe_outSQ
);

   logic              en_q, en_d;
   logic              pend_q, pend_d;
   logic [23:0]       stage_q, stage_d;
   logic [23:0]       active_q, active_d;
   logic [15:0]       step_q, step_d;
   logic [1:0]        sync1_q, sel_q;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              sq_q, sq_d;
   logic [EDGE_W-1:0] edge_q, edge_d;
   logic [31:0]       rdata_q, rdata_d;

   logic              wr, rd;
   logic [1:0]        a;
   logic [9:0]        sum10;
   logic [7:0]        sel_val;
   logic [23:0]       prod;
   logic [ACC_W-1:0]  inc, acc_sum;
   logic              carry, run, commit, rise, clr;
   logic [31:0]       status;
   logic              unused_ok;

   assign unused_ok = ^{avs_address[4:2], avs_writedata[30:24]};

   always_comb begin
      wr    = avs_chipselect & avs_write;
      rd    = avs_chipselect & avs_read;
      a     = avs_address[1:0];
      sum10 = 10'(active_q[23:16]) + 10'(active_q[15:8]) + 10'(active_q[7:0]);
      case (sel_q)
         2'b00:   sel_val = active_q[23:16];
         2'b11:   sel_val = active_q[15:8];
         2'b10:   sel_val = active_q[7:0];
         default: sel_val = (sum10 > 10'd255) ? 8'hFF : sum10[7:0];
      endcase
      prod             = {16'b0, sel_val} * {8'b0, step_q};
      inc              = ACC_W'(prod);
      run              = en_q & (inc != '0);
      {carry, acc_sum} = {1'b0, acc_q} + {1'b0, inc};
      acc_d            = run ? acc_sum : '0;
      // outSQ is forced low as soon as the generator stops, so disabling never stretches a pulse.
      sq_d             = run & acc_q[ACC_W-1];
      rise             = sq_d & ~sq_q;
      commit           = pend_q & (~run | carry);
      clr              = wr & (a == 2'd0) & avs_writedata[31];
   end

   always_comb begin
      en_d     = en_q;
      step_d   = step_q;
      stage_d  = stage_q;
      pend_d   = commit ? 1'b0 : pend_q;
      active_d = commit ? stage_q : active_q;
      if (wr) begin
         case (a)
            2'd0: en_d = avs_writedata[0];
            2'd1: begin
               stage_d = avs_writedata[23:0];
               pend_d  = 1'b1;
            end
            2'd2: step_d = avs_writedata[15:0];
            default: ;
         endcase
      end
      if (clr)       edge_d = '0;
      else if (rise) edge_d = edge_q + EDGE_W'(1);
      else           edge_d = edge_q;
   end

   always_comb begin
      status              = '0;
      status[0]           = en_q;
      status[1]           = pend_q;
      status[3:2]         = sel_q;
      status[16 +: EDGE_W] = edge_q;
      rdata_d             = rdata_q;
      if (rd) begin
         case (a)
            2'd0:    rdata_d = {31'b0, en_q};
            2'd1:    rdata_d = {8'b0, active_q};
            2'd2:    rdata_d = {16'b0, step_q};
            default: rdata_d = status;
         endcase
      end
   end

   always_ff @(posedge csi_CLK or posedge csi_reset) begin
      if (csi_reset) begin
         en_q     <= 1'b0;
         pend_q   <= 1'b0;
         stage_q  <= '0;
         active_q <= '0;
         step_q   <= 16'(STEP_RST);
         sync1_q  <= '0;
         sel_q    <= '0;
         acc_q    <= '0;
         sq_q     <= 1'b0;
         edge_q   <= '0;
         rdata_q  <= '0;
      end else begin
         en_q     <= en_d;
         pend_q   <= pend_d;
         stage_q  <= stage_d;
         active_q <= active_d;
         step_q   <= step_d;
         sync1_q  <= coe_Sctrl;
         sel_q    <= sync1_q;
         acc_q    <= acc_d;
         sq_q     <= sq_d;
         edge_q   <= edge_d;
         rdata_q  <= rdata_d;
      end
   end

   assign avs_readdata = rdata_q;
   assign coe_outSQ    = sq_q;

endmodule
